// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Sequences run-time video mode changes for the beam-position timing
// generator. A request is accepted only while the generator is stable.
// The switch is applied on the next rising VS, or after a timeout if VS
// never arrives. The generator is then held in reset for RST_CYCLES.
// oStable is reported once SETTLE_FRAMES further frames have started.
module video_mode_ctrl #(
  parameter int NUM_MODES     = 4,
  parameter int DEF_MODE      = 0,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_FRAMES = 2,
  parameter int TIMEOUT       = 1048576
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iReqValid,
  input  logic [1:0]  iReqMode,
  output logic        oReqReady,
  input  logic        iVS,
  output logic        oTgRst,
  output logic [1:0]  oMode,
  output logic [12:0] oHActive,
  output logic [12:0] oVActive,
  output logic        oStable,
  output logic        oErr
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int FC_W = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0]      DEF_MODE_L = 2'(DEF_MODE);
  localparam logic [RC_W-1:0] RC_LOAD    = RC_W'(RST_CYCLES - 1);
  localparam logic [FC_W-1:0] FC_LOAD    = FC_W'(SETTLE_FRAMES);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SETTLE,
    ST_STABLE,
    ST_WAIT_VB
  } state_t;

  // Active resolution per mode, packed as {width, height}.
  function automatic logic [25:0] res_of(input logic [1:0] mode);
    logic [25:0] res;
    case (mode)
      2'd0:    res = {13'd640,  13'd480};
      2'd1:    res = {13'd800,  13'd600};
      2'd2:    res = {13'd1280, 13'd720};
      default: res = {13'd1920, 13'd1080};
    endcase
    return res;
  endfunction

  state_t          r_state, w_state_next;
  logic            r_vs_prev;
  logic [RC_W-1:0] r_rst_cnt, w_rst_cnt_next;
  logic [FC_W-1:0] r_frame_cnt, w_frame_cnt_next;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_next;
  logic [1:0]      r_pending, w_pending_next;
  logic [1:0]      r_mode, w_mode_next;
  logic [25:0]     r_res, w_res_next;
  logic            r_tg_rst, w_tg_rst_next;
  logic            r_err, w_err_next;
  logic            w_vs_edge;
  logic            w_req_bad;

  assign w_vs_edge  = iVS && !r_vs_prev;
  assign w_req_bad  = ({30'd0, iReqMode} >= 32'(NUM_MODES));
  assign w_res_next = res_of(w_mode_next);

  // Next-state and next-output decode for the switch sequence.
  always_comb begin
    w_state_next     = r_state;
    w_rst_cnt_next   = r_rst_cnt;
    w_frame_cnt_next = r_frame_cnt;
    w_to_cnt_next    = r_to_cnt;
    w_pending_next   = r_pending;
    w_mode_next      = r_mode;
    w_tg_rst_next    = r_tg_rst;
    w_err_next       = 1'b0;
    case (r_state)
      ST_RESET: begin
        // VS edges are ignored here, including on the exit cycle.
        if (r_rst_cnt == '0) begin
          w_tg_rst_next    = 1'b0;
          w_frame_cnt_next = FC_LOAD;
          w_state_next     = (SETTLE_FRAMES == 0) ? ST_STABLE : ST_SETTLE;
        end else begin
          w_rst_cnt_next = r_rst_cnt - RC_W'(1);
        end
      end
      ST_SETTLE: begin
        if (w_vs_edge) begin
          w_frame_cnt_next = r_frame_cnt - FC_W'(1);
          if (r_frame_cnt == FC_W'(1)) begin
            w_state_next = ST_STABLE;
          end
        end
      end
      ST_STABLE: begin
        if (iReqValid) begin
          if (w_req_bad) begin
            w_err_next = 1'b1;
          end else if (iReqMode != r_mode) begin
            w_pending_next = iReqMode;
            w_to_cnt_next  = '0;
            w_state_next   = ST_WAIT_VB;
          end
        end
      end
      ST_WAIT_VB: begin
        w_to_cnt_next = r_to_cnt + TO_W'(1);
        // An edge on the timeout cycle still yields a single switch.
        if (w_vs_edge || (r_to_cnt == TO_LAST)) begin
          w_mode_next    = r_pending;
          w_tg_rst_next  = 1'b1;
          w_rst_cnt_next = RC_LOAD;
          w_state_next   = ST_RESET;
        end
      end
    endcase
  end

  // State and output registers; reset restarts the generator in DEF_MODE.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state     <= ST_RESET;
      r_vs_prev   <= 1'b0;
      r_rst_cnt   <= RC_LOAD;
      r_frame_cnt <= '0;
      r_to_cnt    <= '0;
      r_pending   <= DEF_MODE_L;
      r_mode      <= DEF_MODE_L;
      r_res       <= res_of(DEF_MODE_L);
      r_tg_rst    <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_vs_prev   <= iVS;
      r_rst_cnt   <= w_rst_cnt_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_to_cnt    <= w_to_cnt_next;
      r_pending   <= w_pending_next;
      r_mode      <= w_mode_next;
      r_res       <= w_res_next;
      r_tg_rst    <= w_tg_rst_next;
      r_err       <= w_err_next;
    end
  end

  assign oReqReady = (r_state == ST_STABLE);
  assign oStable   = (r_state == ST_STABLE);
  assign oTgRst    = r_tg_rst;
  assign oMode     = r_mode;
  assign oHActive  = r_res[25:13];
  assign oVActive  = r_res[12:0];
  assign oErr      = r_err;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: two instances with different parameters share
// one randomized stimulus stream. A timestamp-based reference model
// predicts every output on every cycle.
module tb_video_mode_ctrl;

  localparam int N_CYCLES = 20000;

  // Instance A: default table size; instance B: 3 modes, short timeout.
  localparam int P_NUM [2] = '{4, 3};
  localparam int P_DEF [2] = '{0, 2};
  localparam int P_RST [2] = '{16, 16};
  localparam int P_SET [2] = '{2, 1};
  localparam int P_TO  [2] = '{300, 50};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, vs;
  logic [1:0]  req_mode;
  logic        a_ready, a_tg_rst, a_stable, a_err;
  logic [1:0]  a_mode;
  logic [12:0] a_h, a_v;
  logic        b_ready, b_tg_rst, b_stable, b_err;
  logic [1:0]  b_mode;
  logic [12:0] b_h, b_v;

  video_mode_ctrl #(
    .NUM_MODES(4), .DEF_MODE(0), .RST_CYCLES(16), .SETTLE_FRAMES(2), .TIMEOUT(300)
  ) u_dut_a (
    .iClk(clk), .iRst(rst), .iReqValid(req_valid), .iReqMode(req_mode),
    .oReqReady(a_ready), .iVS(vs), .oTgRst(a_tg_rst), .oMode(a_mode),
    .oHActive(a_h), .oVActive(a_v), .oStable(a_stable), .oErr(a_err)
  );

  video_mode_ctrl #(
    .NUM_MODES(3), .DEF_MODE(2), .RST_CYCLES(16), .SETTLE_FRAMES(1), .TIMEOUT(50)
  ) u_dut_b (
    .iClk(clk), .iRst(rst), .iReqValid(req_valid), .iReqMode(req_mode),
    .oReqReady(b_ready), .iVS(vs), .oTgRst(b_tg_rst), .oMode(b_mode),
    .oHActive(b_h), .oVActive(b_v), .oStable(b_stable), .oErr(b_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state, per instance.
  int m_mode [2];
  int m_pend [2];
  int m_tg_end [2];    // first cycle with oTgRst low after the last reset
  int m_edges [2];     // VS edges still required before stable
  int m_deadline [2];  // cycle the switch lands if no VS edge arrives
  bit m_wait [2];
  bit m_err [2];
  bit m_vs_prev = 1'b0;

  // Stimulus generator state.
  int vs_phase = 0;
  int vs_period = 100;
  int vs_width = 1;
  int hold_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_h(input int m);
    case (m)
      0: return 640;
      1: return 800;
      2: return 1280;
      default: return 1920;
    endcase
  endfunction

  function automatic int exp_v(input int m);
    case (m)
      0: return 480;
      1: return 600;
      2: return 720;
      default: return 1080;
    endcase
  endfunction

  // Advance instance k's model to the new cycle, given last cycle's inputs.
  task automatic model_step(input int k, input bit edge_seen);
    string p;
    p = (k == 0) ? "A" : "B";
    m_err[k] = 1'b0;
    if (rst) begin
      m_mode[k]   = P_DEF[k];
      m_pend[k]   = P_DEF[k];
      m_tg_end[k] = cyc + P_RST[k];
      m_edges[k]  = P_SET[k];
      m_wait[k]   = 1'b0;
    end else if (cyc - 1 < m_tg_end[k]) begin
      // generator held in reset: VS edges do not count
    end else if (m_wait[k]) begin
      if (edge_seen || cyc == m_deadline[k]) begin
        m_mode[k]   = m_pend[k];
        m_tg_end[k] = cyc + P_RST[k];
        m_edges[k]  = P_SET[k];
        m_wait[k]   = 1'b0;
        $display("cycle %0d %s: switch to mode %0d (%s)", cyc, p, m_mode[k],
                 edge_seen ? "vs" : "timeout");
      end
    end else if (m_edges[k] > 0) begin
      if (edge_seen) m_edges[k]--;
    end else if (req_valid) begin
      if (int'(req_mode) >= P_NUM[k]) begin
        m_err[k] = 1'b1;
        $display("cycle %0d %s: reject mode %0d", cyc, p, req_mode);
      end else if (int'(req_mode) != m_mode[k]) begin
        m_pend[k]     = int'(req_mode);
        m_wait[k]     = 1'b1;
        m_deadline[k] = cyc + P_TO[k];
        $display("cycle %0d %s: accept mode %0d", cyc, p, req_mode);
      end
    end
  endtask

  task automatic check_all(input int k, input logic tg, input logic stable,
                           input logic ready, input logic err, input logic [1:0] mode,
                           input logic [12:0] h, input logic [12:0] v);
    string p;
    bit e_tg, e_st;
    p    = (k == 0) ? "A" : "B";
    e_tg = (cyc < m_tg_end[k]);
    e_st = !m_wait[k] && !e_tg && (m_edges[k] == 0);
    chk({p, ".tg_rst"}, {31'd0, tg},     {31'd0, e_tg});
    chk({p, ".stable"}, {31'd0, stable}, {31'd0, e_st});
    chk({p, ".ready"},  {31'd0, ready},  {31'd0, e_st});
    chk({p, ".err"},    {31'd0, err},    {31'd0, m_err[k]});
    chk({p, ".mode"},   {30'd0, mode},   32'(m_mode[k]));
    chk({p, ".hact"},   {19'd0, h},      32'(exp_h(m_mode[k])));
    chk({p, ".vact"},   {19'd0, v},      32'(exp_v(m_mode[k])));
  endtask

  // Drive inputs for the current cycle.
  task automatic gen_stimulus();
    bit vs_off;
    rst    = (cyc < 3) || (cyc >= 600 && $urandom_range(0, 1499) == 0);
    vs_off = (cyc >= 12000) && ((cyc % 1000) < 450);
    if (vs_phase >= vs_period) begin
      vs_phase  = 0;
      vs_period = (cyc < 600) ? 100 : int'($urandom_range(30, 200));
      vs_width  = (cyc < 600) ? 1 : int'($urandom_range(1, 4));
    end
    vs = !vs_off && (vs_phase < vs_width);
    vs_phase++;
    if (cyc < 600) begin
      req_valid = 1'b0;
      req_mode  = 2'd0;
    end else if (cyc >= 12000 && (cyc % 1000) == 0) begin
      req_valid = 1'b1;
      req_mode  = 2'($urandom_range(0, 3));
      hold_cnt  = 150;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
    end else begin
      req_valid = ($urandom_range(0, 2) == 0);
      req_mode  = 2'($urandom_range(0, 3));
      hold_cnt  = int'($urandom_range(1, 80));
    end
  endtask

  initial begin
    bit edge_seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = 2'd0;
    vs        = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = P_DEF[k];
      m_pend[k] = P_DEF[k];
      m_tg_end[k] = 0;
      m_edges[k] = 0;
      m_deadline[k] = 0;
      m_wait[k] = 1'b0;
      m_err[k] = 1'b0;
    end
    while (cyc < N_CYCLES) begin
      gen_stimulus();
      @(posedge clk);
      cyc++;
      edge_seen = vs && !m_vs_prev;
      m_vs_prev = rst ? 1'b0 : vs;
      model_step(0, edge_seen);
      model_step(1, edge_seen);
      #1;
      check_all(0, a_tg_rst, a_stable, a_ready, a_err, a_mode, a_h, a_v);
      check_all(1, b_tg_rst, b_stable, b_ready, b_err, b_mode, b_h, b_v);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/video_mode_ctrl.md
# video_mode_ctrl

Sequences run-time video mode changes for the beam-position timing generator. Accepts mode-change requests over a valid/ready handshake, waits for a frame boundary (rising VS), holds the timing generator in reset while the new mode's active resolution is applied, then waits a programmable number of frames before reporting the new mode stable. It sits between the host/config logic and the timing generator and owns that generator's reset and resolution inputs.

## Interface

- NUM_MODES, 4: number of valid table entries (1..4).
- DEF_MODE, 0: mode applied after iRst.
- RST_CYCLES, 16: cycles oTgRst is held high per switch (≥1).
- SETTLE_FRAMES, 2: VS rising edges after reset release before oStable (≥0).
- TIMEOUT, 1048576: maximum cycles to wait for VS before forcing the switch (≥1).

Ports:

- iClk  in  1  pixel clock, all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iReqValid  in  1  mode-change request valid.
- iReqMode  in  2  requested mode index.
- oReqReady  out  1  request accepted when iReqValid && oReqReady.
- iVS  in  1  vertical sync from the timing generator, active-high.
- oTgRst  out  1  synchronous reset to the timing generator.
- oMode  out  2  current applied mode.
- oHActive  out  13  active width of oMode.
- oVActive  out  13  active height of oMode.
- oStable  out  1  timing generator running in oMode and settled.
- oErr  out  1  one-cycle pulse: rejected (out-of-range) request.

## Operation

- Mode table (oHActive x oVActive): 0: 640x480, 1: 800x600, 2: 1280x720, 3: 1920x1080. oHActive/oVActive are registered together with oMode and always match it.
- VS edge: vsPrev <= iVS every cycle (reset to 0); edge = iVS && !vsPrev.
- States:
  - RESET: oTgRst=1. A down-counter runs from RST_CYCLES-1. At 0: oTgRst<=0, the frame counter loads SETTLE_FRAMES, and the state moves to SETTLE, or to STABLE if SETTLE_FRAMES=0.
  - SETTLE: each edge decrements the frame counter. On the edge that reaches 0, the state moves to STABLE.
  - STABLE: oStable=1 and oReqReady=1. On accept:
    - iReqMode ≥ NUM_MODES: oErr pulses and the state stays STABLE.
    - iReqMode == oMode: no-op, stays STABLE.
    - Otherwise: latch pending, clear the timeout counter, go to WAIT_VB.
  - WAIT_VB: oStable=0 and oReqReady=0. The timeout counter increments. On edge, or when the counter reaches TIMEOUT-1: oMode<=pending (and table outputs), oTgRst<=1, load the reset counter, go to RESET.
- oReqReady=0 and oStable=0 in every state except STABLE. Requests presented outside STABLE are not accepted and must be held by the requester.
- Edges during RESET are ignored.
- iRst asserted in any state aborts the sequence and discards pending.

## Timing

- Reset values (cycle after iRst sampled high):
  - oMode=DEF_MODE with its table resolution.
  - oTgRst=1, state RESET.
  - oStable=0, oReqReady=0, oErr=0, vsPrev=0.
- After iRst deasserts, oTgRst remains high for exactly RST_CYCLES cycles, counting from the first cycle iRst is low.
- Accept at cycle T:
  - oReqReady=0 and oStable=0 from T+1.
  - oErr, if any, is high only at T+1.
- iVS high at cycle E with vsPrev=0 while in WAIT_VB:
  - oMode and resolution take the new values at E+1.
  - oTgRst=1 from E+1 through E+RST_CYCLES; low at E+RST_CYCLES+1.
- Timeout with no VS: the switch occurs TIMEOUT cycles after entry to WAIT_VB.
- oStable rises the cycle after the SETTLE_FRAMES-th post-release VS edge.
- oStable rises the cycle after oTgRst falls when SETTLE_FRAMES=0.
- An edge coinciding with the timeout cycle produces one switch only.
- An edge on the same cycle RESET exits is not counted.

## Test plan

- Power-up: iRst high 3 cycles, then low, with iVS pulsing every 100 cycles -> oMode=0, 640x480, oTgRst high exactly 16 cycles; oStable rises one cycle after the 2nd subsequent VS edge; oReqReady=1.
- Switch: in STABLE, request mode 3 with iVS rising 40 cycles later -> oReqReady low next cycle; at VS+1, oMode=3 and 1920x1080; oTgRst high 16 cycles; oStable after 2 VS edges.
- No-op and error:
  - Request mode 0 while in mode 0 -> accepted, oStable stays 1, no oTgRst.
  - With NUM_MODES=3, request 3 -> oErr single-cycle pulse, mode unchanged.
- Timeout: TIMEOUT=50, iVS held low, request mode 1 -> oMode=1 and oTgRst=1 exactly 50 cycles after WAIT_VB entry.
- Backpressure: hold iReqValid with mode 2 during WAIT_VB/RESET/SETTLE of a switch to mode 1 -> no accept until STABLE, then mode 2 is accepted and applied on the next VS.
- Mid-operation reset: iRst pulsed during WAIT_VB (pending mode 2) and again during SETTLE -> each returns oMode=DEF_MODE, a full 16-cycle oTgRst, and pending discarded.
